// File: rtl/framer_pkg.sv
// Shared types and helpers for the packet framer: FSM state encoding,
// ASCII offsets and the nibble-to-ASCII conversion.
// Pure declarations; no latency, no backpressure.
package framer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        CSUM,
        TERM
    } state_e;

    localparam logic [7:0] ASCII_ZERO      = 8'h30;
    localparam logic [7:0] ASCII_ALPHA_OFS = 8'h37;

    // 0-9 -> '0'-'9', 10-15 -> 'A'-'F'
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib <= 4'd9) begin
            return ASCII_ZERO + {4'h0, nib};
        end else begin
            return ASCII_ALPHA_OFS + {4'h0, nib};
        end
    endfunction

endpackage

// File: rtl/packet_framer_nibble_to_ascii.sv
// Converts one hex nibble to its upper-case ASCII character.
// Latency: combinational.
// Backpressure: none; pure function of the input.
// Ports: nib_i (4-bit nibble), char_o (8-bit ASCII code).
module nibble_to_ascii
    import framer_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [7:0] char_o
);

    assign char_o = nib2ascii(nib_i);

endmodule

// File: rtl/packet_framer.sv
// Serialises a captured wide packet into a framed byte stream with checksum
// (hex: DATA chars, 2 csum chars, terminator; binary: 2 sync bytes, DATA, csum).
// Latency: first byte valid 2 cycles after the capture pulse, then 1 byte/cycle.
// Backpressure: byte_out held stable while byte_valid && !byte_ready; packets
// arriving while a frame is in flight are counted in 'dropped' and discarded.
// Ports: clk, reset (async active-low), enable, packet_in/packet_valid (capture),
//        byte_out/byte_valid/byte_ready (byte handshake), busy, frame_done, dropped.
module packet_framer
    import framer_pkg::*;
#(
    parameter int          PACKET_SIZE = 256,
    parameter bit          BINARY      = 1'b0,
    parameter logic [15:0] SYNC_WORD   = 16'hA55A,
    parameter logic [7:0]  TERMINATOR  = 8'h0D
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [PACKET_SIZE-1:0] packet_in,
    input  logic                   packet_valid,
    output logic                   busy,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   frame_done,
    output logic [15:0]            dropped
);

    localparam int IDX_W = $clog2(PACKET_SIZE / 4) + 1;
    localparam int POS_W = $clog2(PACKET_SIZE);
    // Index of the last DATA byte; the counter stops exactly here.
    localparam logic [IDX_W-1:0] LAST_IDX =
        BINARY ? IDX_W'(PACKET_SIZE / 8 - 1) : IDX_W'(PACKET_SIZE / 4 - 1);

    state_e                   state_q, state_d;
    logic [PACKET_SIZE-1:0]   snap_q;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [7:0]               csum_q, csum_d;
    logic [7:0]               byte_q, byte_d;
    logic                     byte_valid_q;
    logic                     busy_q;
    logic                     frame_done_q;
    logic [15:0]              dropped_q;

    logic                     accept;
    logic [POS_W-1:0]         hex_lsb;
    logic [POS_W-1:0]         bin_lsb;
    logic [3:0]               nib_sel;
    logic [7:0]               nib_char;

    assign accept = byte_valid_q & byte_ready;

    // Position advance; the checksum absorbs a DATA byte only when it is accepted.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        csum_d  = csum_q;
        if (accept) begin
            unique case (state_q)
                HEADER: begin
                    if (idx_q == IDX_W'(1)) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                DATA: begin
                    csum_d = csum_q + byte_q;
                    if (idx_q == LAST_IDX) begin
                        state_d = CSUM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                CSUM: begin
                    if (BINARY || idx_q == IDX_W'(1)) begin
                        state_d = BINARY ? IDLE : TERM;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                TERM: begin
                    state_d = IDLE;
                    idx_d   = '0;
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Byte for the next position, so it can be registered on the accepting
    // edge and the stream keeps 1 byte/cycle. csum_d already includes the
    // final DATA byte when stepping into CSUM.
    always_comb begin
        hex_lsb = POS_W'(PACKET_SIZE - 4) - POS_W'({idx_d, 2'b00});
        bin_lsb = POS_W'(PACKET_SIZE - 8) - POS_W'({idx_d, 3'b000});
        if (state_d == CSUM) begin
            nib_sel = (idx_d == '0) ? csum_d[7:4] : csum_d[3:0];
        end else begin
            nib_sel = snap_q[hex_lsb +: 4];
        end
    end

    nibble_to_ascii u_nib2asc (
        .nib_i  (nib_sel),
        .char_o (nib_char)
    );

    always_comb begin
        byte_d = '0;
        unique case (state_d)
            HEADER:  byte_d = (idx_d == '0) ? SYNC_WORD[15:8] : SYNC_WORD[7:0];
            DATA:    byte_d = BINARY ? snap_q[bin_lsb +: 8] : nib_char;
            CSUM:    byte_d = BINARY ? csum_d : nib_char;
            TERM:    byte_d = TERMINATOR;
            default: byte_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            snap_q       <= '0;
            idx_q        <= '0;
            csum_q       <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            dropped_q    <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (state_q == IDLE) begin
                if (packet_valid && enable) begin
                    snap_q  <= packet_in;
                    csum_q  <= '0;
                    idx_q   <= '0;
                    busy_q  <= 1'b1;
                    state_q <= BINARY ? HEADER : DATA;
                end
            end else begin
                if (packet_valid && dropped_q != 16'hFFFF) begin
                    dropped_q <= dropped_q + 16'd1;
                end
                if (!byte_valid_q) begin
                    // First byte of the frame: present it without advancing.
                    byte_q       <= byte_d;
                    byte_valid_q <= 1'b1;
                end else if (accept) begin
                    state_q <= state_d;
                    idx_q   <= idx_d;
                    csum_q  <= csum_d;
                    if (state_d == IDLE) begin
                        byte_q       <= '0;
                        byte_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end else begin
                        byte_q <= byte_d;
                    end
                end
            end
        end
    end

    assign busy       = busy_q;
    assign byte_out   = byte_q;
    assign byte_valid = byte_valid_q;
    assign frame_done = frame_done_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_packet_framer.sv
// Directed bench for packet_framer: a hex-mode and a binary-mode instance
// (PACKET_SIZE=16) sharing clock, reset, enable, packet_in and byte_ready.
module tb_packet_framer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        byte_ready;
    logic [15:0] packet_in;
    logic        pv_h, pv_b;

    logic        busy_h, vld_h, done_h;
    logic [7:0]  byte_h;
    logic [15:0] drop_h;
    logic        busy_b, vld_b, done_b;
    logic [7:0]  byte_b;
    logic [15:0] drop_b;

    int tests = 0;
    int fails = 0;

    packet_framer #(.PACKET_SIZE(16), .BINARY(1'b0)) u_hex (
        .clk(clk), .reset(reset), .enable(enable), .packet_in(packet_in),
        .packet_valid(pv_h), .busy(busy_h), .byte_out(byte_h), .byte_valid(vld_h),
        .byte_ready(byte_ready), .frame_done(done_h), .dropped(drop_h)
    );

    packet_framer #(.PACKET_SIZE(16), .BINARY(1'b1)) u_bin (
        .clk(clk), .reset(reset), .enable(enable), .packet_in(packet_in),
        .packet_valid(pv_b), .busy(busy_b), .byte_out(byte_b), .byte_valid(vld_b),
        .byte_ready(byte_ready), .frame_done(done_b), .dropped(drop_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor on the falling edge: accepted bytes, done pulses, stall stability.
    logic [7:0] q_h[$];
    logic [7:0] q_b[$];
    int         done_cnt_h = 0, done_cnt_b = 0;
    int         done_err_h = 0, done_err_b = 0;
    int         stall_err_h = 0;
    logic       prev_vld_h = 1'b0, prev_rdy_h = 1'b0;
    logic [7:0] prev_byte_h = 8'h00;

    always @(negedge clk) begin
        if (reset) begin
            if (vld_h && byte_ready) q_h.push_back(byte_h);
            if (vld_b && byte_ready) q_b.push_back(byte_b);
            if (done_h) begin
                done_cnt_h++;
                if (busy_h || vld_h) done_err_h++;
            end
            if (done_b) begin
                done_cnt_b++;
                if (busy_b || vld_b) done_err_b++;
            end
            if (prev_vld_h && !prev_rdy_h && (vld_h !== 1'b1 || byte_h !== prev_byte_h))
                stall_err_h++;
        end
        prev_vld_h  = vld_h & reset;
        prev_rdy_h  = byte_ready;
        prev_byte_h = byte_h;
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        pv_h = 1'b0; pv_b = 1'b0; enable = 1'b1; byte_ready = 1'b1; packet_in = '0;
        repeat (2) step();
        reset = 1'b1;
        step();
    endtask

    task automatic send(input bit bin, input logic [15:0] data);
        packet_in = data;
        if (bin) pv_b = 1'b1; else pv_h = 1'b1;
        step();
        pv_h = 1'b0; pv_b = 1'b0;
    endtask

    task automatic wait_done(input bit bin, input int base, input int max_cyc, output bit ok);
        for (int i = 0; i < max_cyc; i++) begin
            if ((bin ? done_cnt_b : done_cnt_h) > base) break;
            step();
        end
        ok = ((bin ? done_cnt_b : done_cnt_h) > base);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pv_h = 1'b0; pv_b = 1'b0; enable = 1'b1; byte_ready = 1'b1; packet_in = '0;
        step();
        tests++;
        if ({busy_h, vld_h, done_h, byte_h, drop_h} !== 27'd0) begin
            fails++;
            $display("FAIL reset_hex: got %b_%b_%b_%h_%h required all zero", busy_h, vld_h, done_h, byte_h, drop_h);
        end
        tests++;
        if ({busy_b, vld_b, done_b, byte_b, drop_b} !== 27'd0) begin
            fails++;
            $display("FAIL reset_bin: got %b_%b_%b_%h_%h required all zero", busy_b, vld_b, done_b, byte_b, drop_b);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_hex_frame();
        logic [7:0] exp [7] = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h45, 8'h41, 8'h0D};
        int  b0 = q_h.size();
        int  d0 = done_cnt_h;
        int  e0 = done_err_h;
        bit  ok;
        send(1'b0, 16'h1A2F);
        tests++;
        if (busy_h !== 1'b1) begin fails++; $display("FAIL hex_busy_rise: got %b required 1", busy_h); end
        wait_done(1'b0, d0, 40, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL hex_timeout: frame_done not seen within 40 cycles"); end
        repeat (5) step();
        tests++;
        if (q_h.size() - b0 != 7) begin fails++; $display("FAIL hex_count: got %0d bytes required 7", q_h.size() - b0); end
        for (int i = 0; i < 7; i++) begin
            logic [7:0] got;
            got = (b0 + i < q_h.size()) ? q_h[b0 + i] : 8'hxx;
            tests++;
            if (got !== exp[i]) begin fails++; $display("FAIL hex_byte%0d: got %h required %h", i, got, exp[i]); end
        end
        tests++;
        if (done_cnt_h - d0 != 1) begin fails++; $display("FAIL hex_done_pulses: got %0d required 1", done_cnt_h - d0); end
        tests++;
        if (done_err_h != e0) begin fails++; $display("FAIL hex_done_busy: busy/valid high with frame_done, count %0d required 0", done_err_h - e0); end
    endtask

    task automatic test_bin_frame();
        logic [7:0] exp [5] = '{8'hA5, 8'h5A, 8'h1A, 8'h2F, 8'h49};
        int  b0 = q_b.size();
        int  d0 = done_cnt_b;
        int  e0 = done_err_b;
        bit  ok;
        send(1'b1, 16'h1A2F);
        wait_done(1'b1, d0, 40, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL bin_timeout: frame_done not seen within 40 cycles"); end
        repeat (5) step();
        tests++;
        if (q_b.size() - b0 != 5) begin fails++; $display("FAIL bin_count: got %0d bytes required 5", q_b.size() - b0); end
        for (int i = 0; i < 5; i++) begin
            logic [7:0] got;
            got = (b0 + i < q_b.size()) ? q_b[b0 + i] : 8'hxx;
            tests++;
            if (got !== exp[i]) begin fails++; $display("FAIL bin_byte%0d: got %h required %h", i, got, exp[i]); end
        end
        tests++;
        if (done_cnt_b - d0 != 1 || done_err_b != e0) begin
            fails++; $display("FAIL bin_done: got %0d pulses, %0d with busy/valid high, required 1 and 0", done_cnt_b - d0, done_err_b - e0);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [7] = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h45, 8'h41, 8'h0D};
        int  b0 = q_h.size();
        int  d0 = done_cnt_h;
        int  s0 = stall_err_h;
        int  c  = 0;
        send(1'b0, 16'h1A2F);
        while (done_cnt_h == d0 && c < 100) begin
            byte_ready = (c >= 6 && c < 11) ? 1'b0 : ((c % 2) == 1);
            step();
            c++;
        end
        byte_ready = 1'b1;
        tests++;
        if (done_cnt_h == d0) begin fails++; $display("FAIL bp_timeout: frame_done not seen within 100 cycles"); end
        repeat (3) step();
        tests++;
        if (q_h.size() - b0 != 7) begin fails++; $display("FAIL bp_count: got %0d bytes required 7", q_h.size() - b0); end
        for (int i = 0; i < 7; i++) begin
            logic [7:0] got;
            got = (b0 + i < q_h.size()) ? q_h[b0 + i] : 8'hxx;
            tests++;
            if (got !== exp[i]) begin fails++; $display("FAIL bp_byte%0d: got %h required %h", i, got, exp[i]); end
        end
        tests++;
        if (stall_err_h != s0) begin fails++; $display("FAIL bp_stable: got %0d unstable stalled cycles required 0", stall_err_h - s0); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp [7] = '{8'h31, 8'h41, 8'h32, 8'h46, 8'h45, 8'h41, 8'h0D};
        int  b0, d0;
        bit  ok;
        reset_dut();
        b0 = q_h.size();
        d0 = done_cnt_h;
        send(1'b0, 16'h1A2F);
        // Edge 8 after capture is the TERM accept; pulses land on edges 2, 5, 8.
        for (int c = 1; c <= 8; c++) begin
            pv_h      = (c == 2 || c == 5 || c == 8);
            packet_in = pv_h ? 16'hFFFF : 16'h0000;
            step();
        end
        pv_h = 1'b0;
        wait_done(1'b0, d0, 20, ok);
        repeat (5) step();
        tests++;
        if (drop_h !== 16'd3) begin fails++; $display("FAIL ovr_dropped: got %0d required 3", drop_h); end
        tests++;
        if (done_cnt_h - d0 != 1 || busy_h !== 1'b0) begin
            fails++; $display("FAIL ovr_single_frame: got %0d frames busy=%b required 1 frame busy=0", done_cnt_h - d0, busy_h);
        end
        for (int i = 0; i < 7; i++) begin
            logic [7:0] got;
            got = (b0 + i < q_h.size()) ? q_h[b0 + i] : 8'hxx;
            tests++;
            if (got !== exp[i]) begin fails++; $display("FAIL ovr_byte%0d: got %h required %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_gating();
        int b0 = q_h.size();
        int d0 = done_cnt_h;
        bit saw_busy = 1'b0;
        logic [15:0] drop0 = drop_h;
        enable = 1'b0;
        send(1'b0, 16'h1A2F);
        for (int i = 0; i < 12; i++) begin
            if (busy_h || vld_h) saw_busy = 1'b1;
            step();
        end
        enable = 1'b1;
        tests++;
        if (saw_busy || q_h.size() != b0 || done_cnt_h != d0) begin
            fails++; $display("FAIL gate_no_frame: got busy_seen=%b bytes=%0d required 0 and 0", saw_busy, q_h.size() - b0);
        end
        tests++;
        if (drop_h !== drop0) begin fails++; $display("FAIL gate_dropped: got %0d required %0d", drop_h, drop0); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp [7] = '{8'h30, 8'h30, 8'h46, 8'h46, 8'h45, 8'h43, 8'h0D};
        int  b0 = q_h.size();
        int  d0;
        int  c = 0;
        bit  ok;
        send(1'b0, 16'h1A2F);
        while (q_h.size() - b0 < 2 && c < 20) begin step(); c++; end
        #2;
        reset = 1'b0;
        #1;
        tests++;
        if ({busy_h, vld_h, done_h, byte_h, drop_h} !== 27'd0) begin
            fails++; $display("FAIL midreset_async: got %b_%b_%b_%h_%h required all zero", busy_h, vld_h, done_h, byte_h, drop_h);
        end
        step();
        step();
        reset = 1'b1;
        step();
        b0 = q_h.size();
        d0 = done_cnt_h;
        send(1'b0, 16'h00FF);
        wait_done(1'b0, d0, 40, ok);
        repeat (3) step();
        tests++;
        if (!ok || q_h.size() - b0 != 7) begin fails++; $display("FAIL midreset_count: got %0d bytes required 7", q_h.size() - b0); end
        for (int i = 0; i < 7; i++) begin
            logic [7:0] got;
            got = (b0 + i < q_h.size()) ? q_h[b0 + i] : 8'hxx;
            tests++;
            if (got !== exp[i]) begin fails++; $display("FAIL midreset_byte%0d: got %h required %h", i, got, exp[i]); end
        end
    endtask

    task automatic test_saturation();
        int  d0;
        int  s0;
        bit  ok;
        reset_dut();
        d0 = done_cnt_h;
        s0 = stall_err_h;
        byte_ready = 1'b0;
        send(1'b0, 16'h1A2F);
        pv_h = 1'b1;
        packet_in = 16'h5555;
        repeat (70000) step();
        pv_h = 1'b0;
        step();
        tests++;
        if (drop_h !== 16'hFFFF) begin fails++; $display("FAIL sat_dropped: got %h required ffff", drop_h); end
        tests++;
        if (vld_h !== 1'b1 || byte_h !== 8'h31 || stall_err_h != s0) begin
            fails++; $display("FAIL sat_hold: got valid=%b byte=%h required valid=1 byte=31", vld_h, byte_h);
        end
        byte_ready = 1'b1;
        wait_done(1'b0, d0, 40, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL sat_timeout: frame_done not seen within 40 cycles"); end
    endtask

    initial begin
        test_reset();
        test_hex_frame();
        test_bin_frame();
        test_backpressure();
        test_overrun();
        test_gating();
        test_reset_midframe();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
